alu_issue_stage: RTL and testbench

//  Upstream neighbour of the execution-unit ALU: buffers decoded ALU ops, drives the ALU's

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_issue_fifo.sv | 67 ++++++
 rtl/alu_issue_stage.sv | 166 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage.
// ALU control codes, issue-stage FSM states and the legal-op check used
// when the ALU_ILLEGAL_TRAP_EN build option is enabled.
package alu_pkg;

  // Operand and result widths are fixed by the ALU this stage feeds.
  localparam int OPW   = 5;
  localparam int RES_W = 32;

  // ALU control codes; 0000 is the idle code (ALU returns 0).
  typedef enum logic [3:0] {
    ALU_NOP  = 4'b0000,
    ALU_ADD  = 4'b0001,
    ALU_SUB  = 4'b0010,
    ALU_AND  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_AND2 = 4'b0110,
    ALU_OR   = 4'b0111,
    ALU_MUL  = 4'b1000,
    ALU_LT   = 4'b1001,
    ALU_GT   = 4'b1010,
    ALU_EQ   = 4'b1011
  } alu_op_e;

  // Issue-stage FSM states; TRAP is only reachable with ALU_ILLEGAL_TRAP_EN.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ISSUE  = 2'b01,
    RESULT = 2'b10,
    TRAP   = 2'b11
  } issue_state_e;

  // An op is legal when its code lies in the ADD..EQ range.
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op >= 4'(ALU_ADD)) && (op <= 4'(ALU_EQ));
  endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Op buffer for the ALU issue stage.
// DEPTH entries (power of two) of packed {op, operand_1, operand_2, tag}.
// A push into a full FIFO is dropped even if a pop happens in the same
// cycle; the producer sees this through full (in_ready = !full).
module alu_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (count_r == CNT_W'(DEPTH));
  assign empty  = (count_r == {CNT_W{1'b0}});
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;
  assign rdata  = mem_r[rd_ptr_r];

  // Storage: write the entry at the write pointer on an accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: buffers decoded ALU ops, drives the ALU's registered
// inputs one op at a time and offers the ALU result to writeback with its tag.
// Build option: ALU_ILLEGAL_TRAP_EN -- illegal op codes retire through TRAP
// with wb_err=1 instead of being issued to the ALU.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [OPW-1:0]   in_operand_1,
  input  logic [OPW-1:0]   in_operand_2,
  input  logic [TAG_W-1:0] in_tag,
  output logic [OPW-1:0]   alu_operand_1,
  output logic [OPW-1:0]   alu_operand_2,
  output logic [3:0]       alu_control,
  input  logic [RES_W-1:0] alu_result,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [RES_W-1:0] wb_result,
  output logic [TAG_W-1:0] wb_tag,
  output logic             wb_err
);

  localparam int ENTRY_W = 4 + 2 * OPW + TAG_W;

  issue_state_e       state_r;
  issue_state_e       state_nxt_s;
  logic               load_s;
  logic               clear_ctl_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [ENTRY_W-1:0] fifo_wdata_s;
  logic [ENTRY_W-1:0] fifo_rdata_s;
  logic [3:0]         head_op_s;
  logic [OPW-1:0]     head_opnd1_s;
  logic [OPW-1:0]     head_opnd2_s;
  logic [TAG_W-1:0]   head_tag_s;
  logic [OPW-1:0]     alu_operand_1_r;
  logic [OPW-1:0]     alu_operand_2_r;
  logic [3:0]         alu_control_r;
  logic [TAG_W-1:0]   wb_tag_r;
`ifdef ALU_ILLEGAL_TRAP_EN
  logic               head_legal_s;
`endif

  assign fifo_wdata_s = {in_op, in_operand_1, in_operand_2, in_tag};
  assign {head_op_s, head_opnd1_s, head_opnd2_s, head_tag_s} = fifo_rdata_s;
  assign in_ready = !fifo_full_s;

  alu_issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .pop   (load_s),
    .wdata (fifo_wdata_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

`ifdef ALU_ILLEGAL_TRAP_EN
  assign head_legal_s = is_legal_op(head_op_s);
`endif

  // Next-state logic: decide when to load the FIFO head and where to go.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    clear_ctl_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          load_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s = RESULT;
      end
      RESULT, TRAP: begin
        if (wb_ready) begin
          if (!fifo_empty_s) begin
            load_s = 1'b1;
          end else begin
            clear_ctl_s = 1'b1;
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    if (load_s) begin
`ifdef ALU_ILLEGAL_TRAP_EN
      state_nxt_s = head_legal_s ? ISSUE : TRAP;
`else
      state_nxt_s = ISSUE;
`endif
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // ALU input and tag registers: loaded with the head op, held until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_operand_1_r <= {OPW{1'b0}};
      alu_operand_2_r <= {OPW{1'b0}};
      alu_control_r   <= 4'b0000;
      wb_tag_r        <= {TAG_W{1'b0}};
    end else if (load_s) begin
      wb_tag_r <= head_tag_s;
`ifdef ALU_ILLEGAL_TRAP_EN
      // An illegal op is never presented to the ALU.
      if (head_legal_s) begin
        alu_operand_1_r <= head_opnd1_s;
        alu_operand_2_r <= head_opnd2_s;
        alu_control_r   <= head_op_s;
      end
`else
      alu_operand_1_r <= head_opnd1_s;
      alu_operand_2_r <= head_opnd2_s;
      alu_control_r   <= head_op_s;
`endif
    end else if (clear_ctl_s) begin
      alu_control_r <= 4'b0000;
    end
  end

  assign alu_operand_1 = alu_operand_1_r;
  assign alu_operand_2 = alu_operand_2_r;
  assign alu_control   = alu_control_r;
  assign wb_tag        = wb_tag_r;
  assign wb_result     = (state_r == RESULT) ? alu_result : {RES_W{1'b0}};

`ifdef ALU_ILLEGAL_TRAP_EN
  assign wb_valid = (state_r == RESULT) || (state_r == TRAP);
  assign wb_err   = (state_r == TRAP);
`else
  assign wb_valid = (state_r == RESULT);
  assign wb_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage with a behavioural ALU model.
// Scoreboard: every accepted op queues its expected {result, tag, err};
// every offered writeback is compared in order against the queue head.
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_op = 4'd0;
  logic [OPW-1:0]   in_operand_1 = '0;
  logic [OPW-1:0]   in_operand_2 = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [OPW-1:0]   alu_operand_1;
  logic [OPW-1:0]   alu_operand_2;
  logic [3:0]       alu_control;
  logic [RES_W-1:0] alu_result = '0;
  logic             wb_valid;
  logic             wb_ready = 1'b0;
  logic [RES_W-1:0] wb_result;
  logic [TAG_W-1:0] wb_tag;
  logic             wb_err;

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t        sb_q[$];
  int          retire_cyc[$];
  logic [31:0] retire_res[$];
  logic [3:0]  retire_tag[$];
  logic        retire_err[$];
  int          checks_cnt = 0;
  int          errors_cnt = 0;
  int          cyc = 0;
  bit          stall_prev = 1'b0;

  alu_issue_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_operand_1  (in_operand_1),
    .in_operand_2  (in_operand_2),
    .in_tag        (in_tag),
    .alu_operand_1 (alu_operand_1),
    .alu_operand_2 (alu_operand_2),
    .alu_control   (alu_control),
    .alu_result    (alu_result),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_result     (wb_result),
    .wb_tag        (wb_tag),
    .wb_err        (wb_err)
  );

  always #5 clk = ~clk;

  // ALU arithmetic on zero-extended 32-bit operands; unknown codes give 0.
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [4:0] a, input logic [4:0] b);
    logic [31:0] x;
    logic [31:0] y;
    x = {27'd0, a};
    y = {27'd0, b};
    case (op)
      4'd1:    return x + y;
      4'd2:    return x - y;
      4'd3:    return x & y;
      4'd4:    return x << y;
      4'd5:    return x >> y;
      4'd6:    return x & y;
      4'd7:    return x | y;
      4'd8:    return x * y;
      4'd9:    return (x < y) ? 32'd1 : 32'd0;
      4'd10:   return (x > y) ? 32'd1 : 32'd0;
      4'd11:   return (x == y) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic exp_t expect_op(input logic [3:0] op, input logic [4:0] a, input logic [4:0] b,
                                     input logic [TAG_W-1:0] tag);
    exp_t e;
    e.tag = tag;
`ifdef ALU_ILLEGAL_TRAP_EN
    e.err = !(op >= 4'd1 && op <= 4'd11);
`else
    e.err = 1'b0;
`endif
    e.res = e.err ? 32'd0 : alu_fn(op, a, b);
    return e;
  endfunction

  // The real ALU registers its result from the held inputs every edge.
  always @(posedge clk) alu_result <= alu_fn(alu_control, alu_operand_1, alu_operand_2);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: scoreboard compare on every offered result, record accepted ops.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (stall_prev) check_eq("wb_hold", {31'd0, wb_valid}, 32'd1);
      if (wb_valid) begin
        if (sb_q.size() == 0) begin
          check_eq("wb_unexpected", {31'd0, wb_valid}, 32'd0);
        end else begin
          check_eq("wb_result", wb_result, sb_q[0].res);
          check_eq("wb_tag", {28'd0, wb_tag}, {28'd0, sb_q[0].tag});
          check_eq("wb_err", {31'd0, wb_err}, {31'd0, sb_q[0].err});
          if (wb_ready) begin
            void'(sb_q.pop_front());
            retire_cyc.push_back(cyc);
            retire_res.push_back(wb_result);
            retire_tag.push_back(wb_tag);
            retire_err.push_back(wb_err);
          end
        end
      end
      stall_prev = wb_valid && !wb_ready;
      if (in_valid && in_ready) sb_q.push_back(expect_op(in_op, in_operand_1, in_operand_2, in_tag));
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one op and hold it until accepted (bounded).
  task automatic push_op(input logic [3:0] op, input logic [4:0] a, input logic [4:0] b, input logic [3:0] tag);
    bit done;
    done = 1'b0;
    in_valid = 1'b1; in_op = op; in_operand_1 = a; in_operand_2 = b; in_tag = tag;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) check_eq("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (sb_q.size() == 0 && !wb_valid) done = 1'b1;
    end
    check_eq("drain", sb_q.size(), 32'd0);
  endtask

  initial begin
    int acc;
    int n;
    // Reset state
    repeat (3) tick();
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check_eq("rst_wb_tag", {28'd0, wb_tag}, 32'd0);
    check_eq("rst_wb_err", {31'd0, wb_err}, 32'd0);
    check_eq("rst_alu_ctl", {28'd0, alu_control}, 32'd0);
    check_eq("rst_alu_opnd", {22'd0, alu_operand_1, alu_operand_2}, 32'd0);
    check_eq("rst_wb_result", wb_result, 32'd0);
    rst_n = 1'b1;
    tick();

    // T1: ADD latency and result
    wb_ready = 1'b1;
    push_op(4'b0001, 5'h01, 5'h12, 4'd3);
    @(negedge clk);
    check_eq("t1_lat0", {31'd0, wb_valid}, 32'd0);
    tick();
    @(negedge clk);
    check_eq("t1_issue_ctl", {28'd0, alu_control}, 32'd1);
    check_eq("t1_lat1", {31'd0, wb_valid}, 32'd0);
    tick();
    @(negedge clk);
    check_eq("t1_lat2", {31'd0, wb_valid}, 32'd1);
    check_eq("t1_result", wb_result, 32'h13);
    check_eq("t1_tag", {28'd0, wb_tag}, 32'd3);
    drain();

    // T2: SUB wraps
    push_op(4'b0010, 5'h01, 5'h12, 4'd5);
    tick();
    tick();
    @(negedge clk);
    check_eq("t2_result", wb_result, 32'hFFFF_FFEF);
    check_eq("t2_tag", {28'd0, wb_tag}, 32'd5);
    check_eq("t2_err", {31'd0, wb_err}, 32'd0);
    drain();

    // T3: writeback stall, FIFO fills to DEPTH and refuses the fifth push
    wb_ready = 1'b0;
    push_op(4'b0001, 5'h01, 5'h12, 4'd1);
    tick();
    tick();
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_op = 4'b0111; in_operand_1 = 5'(i); in_operand_2 = 5'd1; in_tag = 4'(i + 8);
      @(negedge clk);
      check_eq("t3_in_ready", {31'd0, in_ready}, (i < 4) ? 32'd1 : 32'd0);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    check_eq("t3_hold_valid", {31'd0, wb_valid}, 32'd1);
    check_eq("t3_hold_result", wb_result, 32'h13);
    check_eq("t3_accepted", acc, 32'd4);
    wb_ready = 1'b1;
    drain();

    // T4: back-to-back ops, one retirement every 2 cycles
    retire_cyc.delete(); retire_res.delete(); retire_tag.delete(); retire_err.delete();
    push_op(4'b0111, 5'd3, 5'd4, 4'd1);
    push_op(4'b1000, 5'd3, 5'd5, 4'd2);
    push_op(4'b1001, 5'd2, 5'd7, 4'd3);
    push_op(4'b1011, 5'd9, 5'd9, 4'd4);
    drain();
    check_eq("t4_count", retire_cyc.size(), 32'd4);
    if (retire_cyc.size() == 4) begin
      check_eq("t4_res0", retire_res[0], 32'd7);
      check_eq("t4_res1", retire_res[1], 32'd15);
      check_eq("t4_res2", retire_res[2], 32'd1);
      check_eq("t4_res3", retire_res[3], 32'd1);
      check_eq("t4_tag3", {28'd0, retire_tag[3]}, 32'd4);
      for (int i = 1; i < 4; i++) check_eq("t4_spacing", retire_cyc[i] - retire_cyc[i-1], 32'd2);
    end

    // T5: illegal op code
    retire_res.delete(); retire_err.delete(); retire_tag.delete();
    push_op(4'b1100, 5'd3, 5'd4, 4'd2);
    @(negedge clk);
    check_eq("t5_valid_early", {31'd0, wb_valid}, 32'd0);
    tick();
    @(negedge clk);
`ifdef ALU_ILLEGAL_TRAP_EN
    check_eq("t5_ctl_unchanged", {28'd0, alu_control}, 32'd0);
    check_eq("t5_trap_valid", {31'd0, wb_valid}, 32'd1);
    check_eq("t5_trap_err", {31'd0, wb_err}, 32'd1);
`else
    check_eq("t5_ctl_issued", {28'd0, alu_control}, 32'hC);
`endif
    drain();
    n = retire_res.size();
    check_eq("t5_retired", n, 32'd1);
    if (n == 1) begin
      check_eq("t5_result", retire_res[0], 32'd0);
      check_eq("t5_tag", {28'd0, retire_tag[0]}, 32'd2);
`ifdef ALU_ILLEGAL_TRAP_EN
      check_eq("t5_err", {31'd0, retire_err[0]}, 32'd1);
`else
      check_eq("t5_err", {31'd0, retire_err[0]}, 32'd0);
`endif
    end

    // T6: reset while in RESULT with 2 ops queued
    wb_ready = 1'b0;
    push_op(4'b0001, 5'd2, 5'd3, 4'd1);
    push_op(4'b0001, 5'd4, 5'd5, 4'd2);
    push_op(4'b0001, 5'd6, 5'd7, 4'd3);
    tick();
    @(negedge clk);
    check_eq("t6_in_result", {31'd0, wb_valid}, 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", {31'd0, wb_valid}, 32'd0);
    check_eq("t6_rst_ctl", {28'd0, alu_control}, 32'd0);
    check_eq("t6_rst_ready", {31'd0, in_ready}, 32'd1);
    check_eq("t6_rst_tag", {28'd0, wb_tag}, 32'd0);
    sb_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    wb_ready = 1'b1;
    repeat (10) tick();
    check_eq("t6_no_stale", {31'd0, wb_valid}, 32'd0);

    // Randomized traffic with random writeback back-pressure
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      in_op = 4'($urandom_range(0, 15));
      in_operand_1 = 5'($urandom);
      in_operand_2 = 5'($urandom);
      in_tag = 4'($urandom);
      wb_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    wb_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
